// File: rtl/autenticacao_sequencial_pkg.sv
// Shared types and display patterns for the sequential code-entry authenticator.
package autenticacao_sequencial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CHECK = 3'd2,
    ST_GRANT = 3'd3,
    ST_DENY  = 3'd4,
    ST_LOCK  = 3'd5
  } auth_state_t;

  // Seven-segment patterns, bit 6 = segment a down to bit 0 = segment g.
  localparam logic [6:0] P_IDLE  = 7'b0000001;
  localparam logic [6:0] P_ENTRY = 7'b1001111;
  localparam logic [6:0] P_CHECK = 7'b1001111;
  localparam logic [6:0] P_GRANT = 7'b1110111;
  localparam logic [6:0] P_DENY  = 7'b1000111;
  localparam logic [6:0] P_LOCK  = 7'b0001110;

  // Maps a state to the pattern shown on the status display.
  function automatic logic [6:0] pattern_for(input auth_state_t s);
    logic [6:0] p;
    p = P_IDLE;
    case (s)
      ST_IDLE:  p = P_IDLE;
      ST_ENTRY: p = P_ENTRY;
      ST_CHECK: p = P_CHECK;
      ST_GRANT: p = P_GRANT;
      ST_DENY:  p = P_DENY;
      ST_LOCK:  p = P_LOCK;
      default:  p = P_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/auth_timer.sv
// Down-counter shared by the GRANT, DENY and LOCK hold states.
// Loading value N-1 makes done rise in the N-th cycle after the load.
module auth_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/autenticacao_sequencial.sv
// Sequential code-entry authenticator: collects CODE_LEN digits, compares them
// with SECRET and shows grant, deny or lockout for a fixed number of cycles.
module autenticacao_sequencial
  import autenticacao_sequencial_pkg::*;
#(
  parameter int                           CODE_LEN     = 4,
  parameter int                           DIGIT_W      = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  SECRET       = 16'h1234,
  parameter int                           MAX_TRIES    = 3,
  parameter int                           GRANT_CYCLES = 8,
  parameter int                           DENY_CYCLES  = 4,
  parameter int                           LOCK_CYCLES  = 20
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               clear,
  output logic [6:0]                         P,
  output logic                               granted,
  output logic                               locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic                               busy
);

  localparam int CODE_W   = CODE_LEN * DIGIT_W;
  localparam int CNT_W    = $clog2(CODE_LEN + 1);
  localparam int TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam int HOLD_GD  = (GRANT_CYCLES > DENY_CYCLES) ? GRANT_CYCLES : DENY_CYCLES;
  localparam int HOLD_MAX = (HOLD_GD > LOCK_CYCLES) ? HOLD_GD : LOCK_CYCLES;
  localparam int TIMER_W  = $clog2(HOLD_MAX + 1);

  auth_state_t        state;
  auth_state_t        next_state;
  logic [CODE_W-1:0]  entry_reg;
  logic [CNT_W-1:0]   digit_cnt;
  logic [TRIES_W-1:0] fail_cnt;
  logic [TRIES_W-1:0] fail_next;
  logic               accept_digit;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;

  auth_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, digit acceptance, timer loading and failure bookkeeping.
  always_comb begin
    next_state   = state;
    accept_digit = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;
    fail_next    = fail_cnt;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (clear) begin
          next_state = ST_IDLE;
        end else if (digit_valid) begin
          accept_digit = 1'b1;
          if (digit_cnt == CNT_W'(CODE_LEN - 1)) begin
            next_state = ST_CHECK;
          end else begin
            next_state = ST_ENTRY;
          end
        end
      end
      ST_CHECK: begin
        timer_load = 1'b1;
        if (entry_reg == SECRET) begin
          next_state  = ST_GRANT;
          timer_value = TIMER_W'(GRANT_CYCLES - 1);
          fail_next   = '0;
        end else if ((int'(fail_cnt) + 1) < MAX_TRIES) begin
          next_state  = ST_DENY;
          timer_value = TIMER_W'(DENY_CYCLES - 1);
          fail_next   = fail_cnt + TRIES_W'(1);
        end else begin
          next_state  = ST_LOCK;
          timer_value = TIMER_W'(LOCK_CYCLES - 1);
        end
      end
      ST_GRANT, ST_DENY: begin
        if (timer_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (timer_done) begin
          next_state = ST_IDLE;
          fail_next  = '0;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Entry register and digit count: shift in accepted digits, wipe on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg <= '0;
      digit_cnt <= '0;
    end else if (accept_digit) begin
      entry_reg <= (entry_reg << DIGIT_W) | CODE_W'(digit);
      digit_cnt <= digit_cnt + CNT_W'(1);
    end else if (next_state == ST_IDLE) begin
      entry_reg <= '0;
      digit_cnt <= '0;
    end
  end

  // Consecutive failure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else begin
      fail_cnt <= fail_next;
    end
  end

  assign P          = pattern_for(state);
  assign granted    = (state == ST_GRANT);
  assign locked     = (state == ST_LOCK);
  assign busy       = (state == ST_CHECK) || (state == ST_GRANT) ||
                      (state == ST_DENY)  || (state == ST_LOCK);
  assign tries_left = TRIES_W'(MAX_TRIES) - fail_cnt;

endmodule
